// File: rtl/binary_counter_n_updown.sv
// WIDTH-bit modulo-MOD up/down counter with load clamp, cascade carry/borrow and sticky wrap flag.
// Define BINCNT_SATURATE_EN to hold at the terminal value instead of wrapping.
module binary_counter_n_updown #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MOD   = 16
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_count,
   input  logic             i_load,
   input  logic             i_up,
   input  logic [WIDTH-1:0] i_in,
   input  logic             i_ack,
   output logic [WIDTH-1:0] o_a,
   output logic             o_co,
   output logic             o_flag
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] r_a;
   logic             r_flag;

   logic [WIDTH-1:0] w_term;
   logic             w_at_term;
   logic             w_co;
   logic [WIDTH-1:0] w_load_val;
   logic [WIDTH-1:0] w_step;
   logic [WIDTH-1:0] w_wrap_val;
   logic [WIDTH-1:0] w_a_next;
   logic             w_flag_next;

   always_comb begin
      w_term    = i_up ? MaxVal : '0;
      w_at_term = (r_a == w_term);
      w_co      = i_count & ~i_load & ~i_clr & w_at_term;
   end

   // Out-of-range load values clamp to the top of the count range.
   assign w_load_val = (32'(i_in) < MOD) ? i_in : MaxVal;
   assign w_step     = i_up ? (r_a + WIDTH'(1)) : (r_a - WIDTH'(1));

`ifdef BINCNT_SATURATE_EN
   assign w_wrap_val = r_a;
`else
   assign w_wrap_val = i_up ? '0 : MaxVal;
`endif

   always_comb begin
      w_a_next = r_a;
      if (i_load) begin
         w_a_next = w_load_val;
      end else if (i_count) begin
         w_a_next = w_at_term ? w_wrap_val : w_step;
      end
   end

   // A terminal event on the same edge as Ack keeps the flag set.
   always_comb begin
      w_flag_next = r_flag;
      if (w_co) begin
         w_flag_next = 1'b1;
      end else if (i_ack) begin
         w_flag_next = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_a    <= '0;
         r_flag <= 1'b0;
      end else begin
         r_a    <= w_a_next;
         r_flag <= w_flag_next;
      end
   end

   assign o_a    = r_a;
   assign o_co   = w_co;
   assign o_flag = r_flag;

endmodule
